// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder (a + b + cin), LSB first, with a
// start/busy/done handshake. Each operation takes WIDTH RUN cycles and one
// DONE cycle.
// Optional feature macro: SERIAL_ADDER_OVF_EN
//   When defined, ovf reports two's-complement overflow, captured with cout.
//   When undefined, ovf is tied to 0 and no flop is added for it.
module serial_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             w_s;
  logic             w_c;
  logic             w_last;

  // Single full-adder cell working on the current LSBs and the carry flop.
  assign w_s    = r_a[0] ^ r_b[0] ^ r_c;
  assign w_c    = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic: start is only honoured in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath. Sum bits are shifted into the top of the operand-A register as
  // A's bits leave the bottom, so A's register doubles as the partial sum.
  // The finished sum and carry are committed on the last RUN edge so that
  // they are already valid during the DONE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= 1'b0;
      r_cnt  <= '0;
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_c   <= cin;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          r_a   <= {w_s, r_a[WIDTH-1:1]};
          r_b   <= r_b >> 1;
          r_c   <= w_c;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_sum  <= {w_s, r_a[WIDTH-1:1]};
            r_cout <= w_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;

  // Signed overflow: carry into the MSB differs from carry out of the MSB.
  always_ff @(posedge clk) begin
    if (rst)                           r_ovf <= 1'b0;
    else if (r_state == S_RUN && w_last) r_ovf <= r_c ^ w_c;
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder (WIDTH=4): directed handshake scenarios plus an
// exhaustive operand sweep and random operations, all checked against an
// arithmetic reference model. Honours SERIAL_ADDER_OVF_EN for ovf.
module tb_serial_adder;

  localparam int unsigned W    = 4;
  localparam int          SMAX = (1 << (W - 1)) - 1;
  localparam int          SMIN = -SMAX - 1;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int unsigned tests = 0;
  int unsigned fails = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: returns {ovf, cout, sum} from plain integer arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    logic [W:0] t;
    logic       o;
    t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    o = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    begin
      int s;
      s = int'($signed(x)) + int'($signed(y)) + (c ? 1 : 0);
      o = (s > SMAX) || (s < SMIN);
    end
`endif
    return {o, t};
  endfunction

  // One operation: start presented before edge N+1, busy for W cycles,
  // done in the cycle after edge N+W+1. With junk=1, start stays high with
  // scrambled operands during RUN and DONE; none of it may be accepted.
  task automatic do_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                        input bit junk, input string tag);
    logic [W+1:0] e;
    e = model(x, y, c);
    @(negedge clk);
    a = x; b = y; cin = c; start = 1'b1;
    for (int k = 1; k <= int'(W); k++) begin
      @(negedge clk);
      chk({tag, "/busy_run"}, 32'(busy), 1);
      chk({tag, "/done_run"}, 32'(done), 0);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); start = junk;
    end
    @(negedge clk);
    chk({tag, "/done_hi"}, 32'(done), 1);
    chk({tag, "/busy_done"}, 32'(busy), 0);
    chk({tag, "/sum"}, 32'(sum), 32'(e[W-1:0]));
    chk({tag, "/cout"}, 32'(cout), 32'(e[W]));
    chk({tag, "/ovf"}, 32'(ovf), 32'(e[W+1]));
    a = W'($urandom); b = W'($urandom); start = junk;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "/done_pulse"}, 32'(done), 0);
    chk({tag, "/busy_idle"}, 32'(busy), 0);
    chk({tag, "/sum_hold"}, 32'(sum), 32'(e[W-1:0]));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst/busy", 32'(busy), 0);
    chk("rst/done", 32'(done), 0);
    chk("rst/sum", 32'(sum), 0);
    chk("rst/cout", 32'(cout), 0);
    chk("rst/ovf", 32'(ovf), 0);
    rst = 1'b0;

    // Basic, wrap and overflow cases.
    do_add(4'h3, 4'h5, 1'b0, 1'b0, "t1");
    do_add(4'hF, 4'h1, 1'b0, 1'b0, "t2a");
    do_add(4'hF, 4'hF, 1'b1, 1'b0, "t2b");
    do_add(4'h7, 4'h1, 1'b0, 1'b0, "t3a");
    do_add(4'h8, 4'h8, 1'b0, 1'b0, "t3b");
    do_add(4'h3, 4'h2, 1'b0, 1'b0, "t3c");

    // Start pulses during RUN and DONE are ignored; no second done.
    do_add(4'h2, 4'h3, 1'b0, 1'b1, "t4");
    repeat (6) begin
      @(negedge clk);
      chk("t4/no_done", 32'(done), 0);
      chk("t4/no_busy", 32'(busy), 0);
    end

    // Reset on the second RUN cycle aborts the operation.
    @(negedge clk);
    a = 4'h6; b = 4'h6; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t5/busy_run1", 32'(busy), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5/busy", 32'(busy), 0);
    chk("t5/done", 32'(done), 0);
    chk("t5/sum", 32'(sum), 0);
    chk("t5/cout", 32'(cout), 0);
    chk("t5/ovf", 32'(ovf), 0);
    repeat (8) begin
      @(negedge clk);
      chk("t5/no_done", 32'(done), 0);
    end
    do_add(4'h6, 4'h6, 1'b0, 1'b0, "t5post");

    // Reset and start in the same cycle: reset wins.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; a = 4'h1; b = 4'h1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rs/busy", 32'(busy), 0);
    chk("rs/sum", 32'(sum), 0);
    @(negedge clk);
    chk("rs/busy2", 32'(busy), 0);

    // Back-to-back with start held high: one result every W+2 cycles.
    @(negedge clk);
    a = 4'h1; b = 4'h1; cin = 1'b0; start = 1'b1;
    for (int k = 1; k <= 3 * int'(W + 2); k++) begin
      @(negedge clk);
      chk("t6/done", 32'(done), 32'((k % int'(W + 2)) == int'(W + 1)));
      chk("t6/busy", 32'(busy), 32'((k % int'(W + 2)) >= 1 && (k % int'(W + 2)) <= int'(W)));
      if (done) chk("t6/sum", 32'(sum), 2);
    end
    start = 1'b0;
    @(negedge clk);

    // Exhaustive sweep, randomly mixing in ignored start pulses.
    for (int x = 0; x < (1 << W); x++)
      for (int y = 0; y < (1 << W); y++)
        for (int c = 0; c < 2; c++)
          do_add(W'(x), W'(y), 1'(c), ($urandom % 4) == 0, "sweep");

    // Random operations.
    repeat (40)
      do_add(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), "rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
